// File: rtl/pulse_tx_pkg.sv
// Shared types and default constants for the pulse-to-level request transmitter
// and its destination-side counterpart.
package pulse_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    ACK_LO = 2'd2
  } pulse_tx_state_e;

  localparam int NUM_STAGES_DEFAULT = 2;
  localparam int PEND_W_DEFAULT     = 3;

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer for a level crossing into the CLK domain.
// All stages clear to 0 on the asynchronous active-low reset.
module bit_sync
  import pulse_tx_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic level,
  output logic synced
);

  logic [NUM_STAGES-1:0] stages;

  // Shift the asynchronous level through the flop chain, oldest sample at the top
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stages <= '0;
    end else begin
      stages <= {stages[NUM_STAGES-2:0], level};
    end
  end

  assign synced = stages[NUM_STAGES-1];

endmodule

// File: rtl/pulse_req_tx.sv
// Source side of a four-phase req/ack handshake: turns single-cycle event
// pulses into a held REQ level and waits for the synchronized ACK to complete
// each rise/fall cycle.
// Optional feature macro PULSE_TX_PEND_EN: when defined, events arriving during
// a transfer are queued in a saturating counter exposed on PEND_CNT; when
// undefined, such events are dropped and flagged on DROP.
module pulse_req_tx
  import pulse_tx_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
  parameter int PEND_W     = PEND_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PULSE_IN,
  input  logic              ACK_ASYNC,
  output logic              REQ,
  output logic              BUSY,
  output logic              DROP
`ifdef PULSE_TX_PEND_EN
  ,
  output logic [PEND_W-1:0] PEND_CNT
`endif
);

  pulse_tx_state_e   state;
  pulse_tx_state_e   state_nxt;
  logic              ack_s;
  logic              pend_nz;
  logic              launch_ev;
  logic              launch;
  logic              drop_nxt;
  logic [PEND_W-1:0] pend_q;

  bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .CLK   (CLK),
    .RST   (RST),
    .level (ACK_ASYNC),
    .synced(ack_s)
  );

  assign pend_nz   = |pend_q;
  assign launch_ev = PULSE_IN | pend_nz;

  // Handshake sequencing: a new transfer may start from IDLE or straight out of
  // ACK_LO once the acknowledge has been seen low again
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (launch_ev) begin
          state_nxt = REQ_HI;
          launch    = 1'b1;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          state_nxt = ACK_LO;
        end
      end
      ACK_LO: begin
        if (!ack_s) begin
          if (launch_ev) begin
            state_nxt = REQ_HI;
            launch    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus a dedicated REQ flop so the outgoing level never glitches
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      REQ   <= 1'b0;
    end else begin
      state <= state_nxt;
      REQ   <= (state_nxt == REQ_HI);
    end
  end

  assign BUSY = (state != IDLE);

`ifdef PULSE_TX_PEND_EN
  logic              consume;
  logic              enqueue;
  logic [PEND_W-1:0] pend_nxt;

  // Queued events launch first; a pulse that did not launch is queued unless full
  always_comb begin
    pend_nxt = pend_q;
    drop_nxt = 1'b0;
    consume  = launch & pend_nz;
    enqueue  = PULSE_IN & ~(launch & ~pend_nz);
    if (consume && !enqueue) begin
      pend_nxt = pend_q - PEND_W'(1);
    end else if (enqueue && !consume) begin
      if (pend_q == '1) begin
        drop_nxt = 1'b1;
      end else begin
        pend_nxt = pend_q + PEND_W'(1);
      end
    end
  end

  // Pending-event counter register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_nxt;
    end
  end

  assign PEND_CNT = pend_q;
`else
  assign pend_q   = '0;
  assign drop_nxt = PULSE_IN & ~launch;
`endif

  // Registered one-cycle flag for an event that could be neither launched nor queued
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DROP <= 1'b0;
    end else begin
      DROP <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_req_tx.sv
// Randomized scoreboard bench for pulse_req_tx. A behavioural model tracks the
// transfer in flight and the queued event count, pushing the expected outputs
// after every edge; a monitor pops and compares on the falling edge. A
// destination responder answers REQ with a randomly delayed ACK level.
// Honours PULSE_TX_PEND_EN the same way as the design.
module tb_pulse_req_tx;

  localparam int NUM_STAGES = 2;
  localparam int PEND_W     = 3;
  localparam int PEND_MAX   = (1 << PEND_W) - 1;

  logic CLK       = 1'b0;
  logic RST       = 1'b1;
  logic PULSE_IN  = 1'b0;
  logic ACK_ASYNC = 1'b0;
  logic REQ;
  logic BUSY;
  logic DROP;
`ifdef PULSE_TX_PEND_EN
  logic [PEND_W-1:0] PEND_CNT;
`endif

  typedef struct {
    bit req;
    bit busy;
    bit drop;
    int pend;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  bit m_req      = 1'b0;
  bit m_busy     = 1'b0;
  int m_queued   = 0;
  int m_launches = 0;
  int m_drops    = 0;
  bit m_hist[$];

  int obs_rises = 0;
  int obs_drops = 0;
  bit prev_req  = 1'b0;

  always #5 CLK = ~CLK;

  pulse_req_tx #(
    .NUM_STAGES(NUM_STAGES),
    .PEND_W    (PEND_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PULSE_IN (PULSE_IN),
    .ACK_ASYNC(ACK_ASYNC),
    .REQ      (REQ),
    .BUSY     (BUSY),
    .DROP     (DROP)
`ifdef PULSE_TX_PEND_EN
    ,
    .PEND_CNT (PEND_CNT)
`endif
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: ack is seen NUM_STAGES edges late; each event is one REQ
  // high/low cycle; queued work goes first, leftover pulses queue or are lost
  always @(posedge CLK or negedge RST) begin
    bit ack_seen;
    bit ready;
    bit pulse_left;
    bit lost;
    bit req_n;
    bit busy_n;
    int queued_n;
    int launched;
    if (!RST) begin
      m_req    <= 1'b0;
      m_busy   <= 1'b0;
      m_queued <= 0;
      m_hist.delete();
      for (int i = 0; i < NUM_STAGES; i++) m_hist.push_back(1'b0);
    end else begin
      ack_seen = m_hist[0];
      void'(m_hist.pop_front());
      m_hist.push_back(ACK_ASYNC);
      req_n      = m_req;
      busy_n     = m_busy;
      queued_n   = m_queued;
      pulse_left = PULSE_IN;
      lost       = 1'b0;
      launched   = 0;
      ready      = !m_busy || (!m_req && !ack_seen);
      if (m_busy && m_req) begin
        if (ack_seen) req_n = 1'b0;
      end else if (ready) begin
        if (queued_n > 0) begin
          queued_n = queued_n - 1;
          req_n    = 1'b1;
          busy_n   = 1'b1;
          launched = 1;
        end else if (pulse_left) begin
          pulse_left = 1'b0;
          req_n      = 1'b1;
          busy_n     = 1'b1;
          launched   = 1;
        end else begin
          busy_n = 1'b0;
        end
      end
      if (pulse_left) begin
`ifdef PULSE_TX_PEND_EN
        if (queued_n < PEND_MAX) queued_n = queued_n + 1;
        else lost = 1'b1;
`else
        lost = 1'b1;
`endif
      end
      m_req      <= req_n;
      m_busy     <= busy_n;
      m_queued   <= queued_n;
      m_launches <= m_launches + launched;
      m_drops    <= m_drops + (lost ? 1 : 0);
      exp_q.push_back('{req_n, busy_n, lost, queued_n});
    end
  end

  // Monitor: compare every presented output cycle against the scoreboard
  always @(negedge CLK) begin
    exp_t e;
    if (RST && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("REQ", int'(REQ), int'(e.req));
      checkOutput("BUSY", int'(BUSY), int'(e.busy));
      checkOutput("DROP", int'(DROP), int'(e.drop));
`ifdef PULSE_TX_PEND_EN
      checkOutput("PEND_CNT", int'(PEND_CNT), e.pend);
`endif
      if (REQ && !prev_req) obs_rises++;
      if (DROP) obs_drops++;
    end
    prev_req = REQ;
  end

  // Destination responder: follows REQ with ACK after a random delay
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (!RST) begin
        ACK_ASYNC = 1'b0;
      end else if (REQ != ACK_ASYNC && $urandom_range(0, 2) == 0) begin
        ACK_ASYNC = REQ;
      end
    end
  end

  task automatic applyStimulus(input int cycles, input int pct);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      #1;
      PULSE_IN = ($urandom_range(0, 99) < pct);
    end
    @(negedge CLK);
    #1;
    PULSE_IN = 1'b0;
  endtask

  task automatic doReset();
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("rst_REQ", int'(REQ), 0);
    checkOutput("rst_BUSY", int'(BUSY), 0);
    checkOutput("rst_DROP", int'(DROP), 0);
`ifdef PULSE_TX_PEND_EN
    checkOutput("rst_PEND_CNT", int'(PEND_CNT), 0);
`endif
    exp_q.delete();
    repeat (2) @(negedge CLK);
    #2;
    RST = 1'b1;
  endtask

  initial begin
    bit found;
    bit done;
    #2;
    RST = 1'b0;
    #1;
    checkOutput("rst_REQ", int'(REQ), 0);
    checkOutput("rst_BUSY", int'(BUSY), 0);
    checkOutput("rst_DROP", int'(DROP), 0);
    repeat (2) @(negedge CLK);
    #2;
    RST = 1'b1;

    applyStimulus(1, 100);
    applyStimulus(25, 0);
    applyStimulus(3, 100);
    applyStimulus(80, 0);
    applyStimulus(9, 100);
    applyStimulus(150, 0);
    applyStimulus(400, 25);
    applyStimulus(100, 0);

    applyStimulus(6, 100);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (REQ) begin
        found = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    checkOutput("req_seen_before_reset", int'(found), 1);
    doReset();

    applyStimulus(300, 40);

    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (!m_busy && m_queued == 0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_done", int'(done), 1);
    repeat (3) @(negedge CLK);
    checkOutput("req_rises", obs_rises, m_launches);
    checkOutput("drop_count", obs_drops, m_drops);
    checkOutput("final_BUSY", int'(BUSY), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
